// File: rtl/display_mux_7s_n.sv
// display_mux_7s_n: time-multiplexed hex driver for N common-anode 7-segment
// digits. Segments, decimal point and anodes are all active-low.
// A new value is captured into a staging register on load and only
// reaches the displayed (shadow) register at a frame boundary, so a frame
// never mixes old and new digits.
// Optional build macro DISPLAY_DIM_EN: PWM brightness within each digit slot,
// set by the bright input. Without it, bright is ignored (full duty).
module display_mux_7s_n #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int CW       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] x,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  load,
  input  logic [3:0]            bright,
  output logic [6:0]            D,
  output logic                  DP,
  output logic [N_DIGITS-1:0]   An,
  output logic                  frame_done
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] stage_x, shadow_x;
  logic [N_DIGITS-1:0]   stage_dp, shadow_dp;
  logic [N_DIGITS-1:0]   stage_blank, shadow_blank;
  logic                  pending;

  logic                  tick, wrap;
  logic [3:0]            nib;
  logic                  dp_sel, blank_sel, lit;
  logic [N_DIGITS-1:0]   an_next;

  assign tick = (cnt == CW'(DIV - 1));
  assign wrap = tick && (idx == IW'(N_DIGITS - 1));

  // Select the shadow fields belonging to the digit currently being scanned.
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = shadow_x[4*i +: 4];
        dp_sel    = shadow_dp[i];
        blank_sel = shadow_blank[i];
      end
    end
  end

`ifdef DISPLAY_DIM_EN
  logic [CW+4:0] on_limit;

  // Anode on-window inside the slot: (bright+1)/16 of the DIV cycles.
  always_comb begin
    on_limit = (((CW+5)'(bright) + (CW+5)'(1)) * (CW+5)'(DIV)) >> 4;
    lit      = ({5'b0, cnt} < on_limit);
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign lit           = 1'b1;
`endif

  // One-cold anode for the current digit, or all dark when blanked / dimmed.
  always_comb begin
    an_next = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx);
    if (blank_sel || !lit)
      an_next = '1;
  end

  // Standard active-low hex font, segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'b1000000;
      4'h1: font = 7'b1111001;
      4'h2: font = 7'b0100100;
      4'h3: font = 7'b0110000;
      4'h4: font = 7'b0011001;
      4'h5: font = 7'b0010010;
      4'h6: font = 7'b0000010;
      4'h7: font = 7'b1111000;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0010000;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b0000011;
      4'hC: font = 7'b1000110;
      4'hD: font = 7'b0100001;
      4'hE: font = 7'b0000110;
      default: font = 7'b0001110;
    endcase
  endfunction

  // Prescaler, digit scan, frame pulse, staged load and registered decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      stage_x      <= '0;
      stage_dp     <= '0;
      stage_blank  <= '0;
      shadow_x     <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      pending      <= 1'b0;
      frame_done   <= 1'b0;
      D            <= 7'h7F;
      DP           <= 1'b1;
      An           <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick)
        idx <= wrap ? '0 : idx + IW'(1);
      frame_done <= wrap;

      if (load) begin
        stage_x     <= x;
        stage_dp    <= dp_in;
        stage_blank <= blank;
      end

      // A load coinciding with the frame boundary bypasses staging.
      if (wrap && load) begin
        shadow_x     <= x;
        shadow_dp    <= dp_in;
        shadow_blank <= blank;
        pending      <= 1'b0;
      end else if (wrap && pending) begin
        shadow_x     <= stage_x;
        shadow_dp    <= stage_dp;
        shadow_blank <= stage_blank;
        pending      <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      D  <= font(nib);
      DP <= ~dp_sel;
      An <= an_next;
    end
  end

endmodule

// File: tb/tb_display_mux_7s_n.sv
// Bench for display_mux_7s_n with N_DIGITS=4, DIV=4. A cycle-level reference
// model predicts every output from elapsed-cycle arithmetic and a simple
// staged/shadow value model.
module tb_display_mux_7s_n;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] x;
  logic [N-1:0]  dp_in, blank;
  logic          load;
  logic [3:0]    bright;
  logic [6:0]    D;
  logic          DP;
  logic [N-1:0]  An;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            k;
  logic [4*N-1:0] m_sx, m_gx;
  logic [N-1:0]  m_sdp, m_gdp, m_sbl, m_gbl;
  bit            m_pend;
  logic [6:0]    e_d;
  logic          e_dp;
  logic [N-1:0]  e_an;
  logic          e_fd;
  logic [6:0]    hexfont [16];

  display_mux_7s_n #(.N_DIGITS(N), .DIV(DIV), .CW(16)) dut (
    .clk(clk), .rst(rst), .x(x), .dp_in(dp_in), .blank(blank), .load(load),
    .bright(bright), .D(D), .DP(DP), .An(An), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Advance one clock, update the model with the inputs seen at that edge,
  // then wait until outputs have settled.
  task automatic step();
    int slot, c, lim;
    bit wr;
    @(posedge clk);
    if (rst) begin
      k = 0; m_sx = '0; m_sdp = '0; m_sbl = '0; m_gx = '0; m_gdp = '0; m_gbl = '0;
      m_pend = 0; e_d = 7'h7F; e_dp = 1'b1; e_an = '1; e_fd = 1'b0;
    end else begin
      k++;
      c    = (k - 1) % DIV;
      slot = ((k - 1) / DIV) % N;
      wr   = ((k - 1) % FR) == FR - 1;
      e_d  = hexfont[(m_sx >> (4*slot)) & 4'hF];
      e_dp = ~m_sdp[slot];
      e_an = m_sbl[slot] ? '1 : ~(N'(1) << slot);
`ifdef DISPLAY_DIM_EN
      lim = ((int'(bright) + 1) * DIV) / 16;
      if (c >= lim) e_an = '1;
`else
      lim = c;
`endif
      e_fd = wr;
      if (wr && load) begin
        m_sx = x; m_sdp = dp_in; m_sbl = blank; m_pend = 0;
      end else if (wr && m_pend) begin
        m_sx = m_gx; m_sdp = m_gdp; m_sbl = m_gbl; m_pend = 0;
      end else if (load) m_pend = 1;
      if (load) begin m_gx = x; m_gdp = dp_in; m_gbl = blank; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; x = '0; dp_in = '0; blank = '0; load = 0; bright = 4'd15;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({An, D, DP, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset: got An=%b D=%b DP=%b fd=%b, want An=1111 D=1111111 DP=1 fd=0",
                 An, D, DP, frame_done);
      end
    end
    rst = 0;
    step();
    tests++;
    if ({An, D} !== {4'b1110, 7'b1000000}) begin
      fails++;
      $display("FAIL reset_release: got An=%b D=%b, want An=1110 D=1000000", An, D);
    end
  endtask

  task automatic test_load_midframe();
    int good = 0;
    for (int i = 0; i < 5; i++) step();
    x = 16'h8F21; dp_in = '0; blank = '0; load = 1;
    step();
    load = 0;
    for (int i = 0; i < 2*FR; i++) begin
      step();
      tests++;
      if ({D, DP, An, frame_done} !== {e_d, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL load_midframe k=%0d: got D=%b DP=%b An=%b fd=%b, want D=%b DP=%b An=%b fd=%b",
                 k, D, DP, An, frame_done, e_d, e_dp, e_an, e_fd);
      end
      if (An == 4'b1011 && D == 7'b0001110) good++;
    end
    tests++;
    if (good != DIV) begin
      fails++;
      $display("FAIL load_midframe_slot2: got %0d cycles of F on An=1011, want %0d", good, DIV);
    end
  endtask

  task automatic test_load_on_wrap();
    int guard = 0;
    int a_cnt = 0;
    while ((k % FR) != FR - 1 && guard < 2*FR) begin step(); guard++; end
    x = 16'hAAAA; dp_in = '0; blank = '0; load = 1;
    step();
    load = 0; x = 16'h1234;
    for (int i = 0; i < 2*FR; i++) begin
      step();
      tests++;
      if ({D, DP, An, frame_done} !== {e_d, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL load_on_wrap k=%0d: got D=%b An=%b fd=%b, want D=%b An=%b fd=%b",
                 k, D, An, frame_done, e_d, e_an, e_fd);
      end
      if (D == 7'b0001000) a_cnt++;
    end
    tests++;
    if (a_cnt != 2*FR) begin
      fails++;
      $display("FAIL load_on_wrap_all_A: got %0d cycles showing A, want %0d", a_cnt, 2*FR);
    end
  endtask

  task automatic test_blank_dp();
    int guard = 0;
    int bad_an = 0;
    int dp_low = 0;
    int fd_cnt = 0;
    x = 16'h5678; dp_in = 4'b0001; blank = 4'b0100; load = 1;
    step();
    load = 0;
    while (!frame_done && guard < 2*FR) begin step(); guard++; end
    tests++;
    if (!frame_done) begin
      fails++;
      $display("FAIL blank_sync: got no frame_done within %0d cycles, want one", 2*FR);
    end
    for (int i = 0; i < FR; i++) begin
      step();
      tests++;
      if ({D, DP, An, frame_done} !== {e_d, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL blank_dp k=%0d: got D=%b DP=%b An=%b, want D=%b DP=%b An=%b",
                 k, D, DP, An, e_d, e_dp, e_an);
      end
      if (An == 4'b1011) bad_an++;
      if (!DP && An == 4'b1110) dp_low++;
      if (!DP && An != 4'b1110) bad_an++;
      if (frame_done) fd_cnt++;
    end
    tests++;
    if (bad_an != 0 || dp_low != DIV || fd_cnt != 1) begin
      fails++;
      $display("FAIL blank_dp_frame: got bad=%0d dp_low=%0d fd=%0d, want bad=0 dp_low=%0d fd=1",
               bad_an, dp_low, fd_cnt, DIV);
    end
  endtask

  task automatic test_reset_midscan();
    int guard = 0;
    while ((k % FR) != 9 && guard < 2*FR) begin step(); guard++; end
    x = 16'h9999; dp_in = 4'b1111; blank = '0; load = 1;
    step();
    load = 0; rst = 1;
    step();
    tests++;
    if ({An, D, DP, frame_done} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_midscan: got An=%b D=%b DP=%b fd=%b, want 1111 1111111 1 0",
               An, D, DP, frame_done);
    end
    rst = 0;
    for (int i = 0; i < 2*FR + 2; i++) begin
      step();
      tests++;
      if ({D, DP, An, frame_done} !== {7'b1000000, 1'b1, e_an, e_fd}) begin
        fails++;
        $display("FAIL reset_midscan_discard k=%0d: got D=%b DP=%b An=%b fd=%b, want D=1000000 DP=1 An=%b fd=%b",
                 k, D, DP, An, frame_done, e_an, e_fd);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      x      = 16'($urandom);
      dp_in  = 4'($urandom);
      blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      load   = ($urandom_range(0, 7) == 0);
      bright = (i < 300) ? 4'd15 : 4'($urandom);
      step();
      tests++;
      if ({D, DP, An, frame_done} !== {e_d, e_dp, e_an, e_fd}) begin
        fails++;
        $display("FAIL random k=%0d: got D=%b DP=%b An=%b fd=%b, want D=%b DP=%b An=%b fd=%b",
                 k, D, DP, An, frame_done, e_d, e_dp, e_an, e_fd);
      end
      if ($countones(~An) > 1) begin
        fails++;
        $display("FAIL random_onehot k=%0d: got An=%b, want at most one low bit", k, An);
      end
    end
    load = 0; bright = 4'd15;
  endtask

`ifdef DISPLAY_DIM_EN
  task automatic test_dim();
    int on;
    int want;
    logic [3:0] lv [3];
    lv[0] = 4'd3; lv[1] = 4'd15; lv[2] = 4'd0;
    for (int j = 0; j < 3; j++) begin
      bright = lv[j];
      on = 0;
      for (int i = 0; i < FR; i++) begin
        step();
        tests++;
        if (An !== e_an) begin
          fails++;
          $display("FAIL dim k=%0d: got An=%b, want %b", k, An, e_an);
        end
        if (An != '1) on++;
      end
      want = N * (((int'(lv[j]) + 1) * DIV) / 16);
      tests++;
      if (on != want) begin
        fails++;
        $display("FAIL dim_duty bright=%0d: got %0d lit cycles, want %0d", lv[j], on, want);
      end
    end
    bright = 4'd15;
  endtask
`endif

  initial begin
    hexfont = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    test_reset();
    test_load_midframe();
    test_load_on_wrap();
    test_blank_dp();
    test_reset_midscan();
`ifdef DISPLAY_DIM_EN
    test_dim();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
